// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: sequences a shared-memory, single-ALU datapath
// through fetch/decode/execute/memory/writeback, one control word per cycle.
// Handshakes with variable-latency memory, watches for stalled accesses and
// flags illegal opcodes. Optional feature macro: JUMP_EN (adds opcode 2 jump).
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15,   // max stall cycles per memory state, 0 = no watchdog
    parameter int TO_W        = 4     // watchdog width, MEM_TIMEOUT < 2**TO_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       retire,
    output logic [1:0] fault,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        JUMP   = 4'd10,
        FAULT  = 4'd15
    } stateT;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_J     = 6'd2;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    localparam logic [TO_W-1:0] TIMEOUT_VAL = TO_W'(MEM_TIMEOUT);

    stateT           curState;
    stateT           nextState;
    logic [1:0]      faultReg;
    logic [1:0]      faultNext;
    logic [TO_W-1:0] waitCnt;
    logic            memWait;
    logic            timeoutHit;

    // A memory state is stalled whenever the access has not completed yet.
    assign memWait    = (curState inside {FETCH, MEMRD, MEMWR}) && !mem_ready;
    assign timeoutHit = (MEM_TIMEOUT != 0) && memWait && (waitCnt == TIMEOUT_VAL);

    assign state = curState;
    assign fault = faultReg;

    // State, sticky fault code and watchdog counter registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            curState <= IDLE;
            faultReg <= FAULT_NONE;
            waitCnt  <= '0;
        end else begin
            curState <= nextState;
            faultReg <= faultNext;
            if (nextState != curState) begin
                waitCnt <= '0;
            end else if (memWait && (waitCnt != '1)) begin
                waitCnt <= waitCnt + 1'b1;
            end
        end
    end

    // Next-state selection and per-state control word decode.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        nextState  = curState;
        faultNext  = faultReg;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_source  = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        retire     = 1'b0;

        case (curState)
            IDLE: begin
                if (run) nextState = FETCH;
            end
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (timeoutHit) begin
                    nextState = FAULT;
                    faultNext = FAULT_TIMEOUT;
                end else if (mem_ready) begin
                    nextState = DECODE;
                end
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:     nextState = EXEC;
                    OP_LW, OP_SW: nextState = MEMADR;
                    OP_BEQ:       nextState = BRANCH;
`ifdef JUMP_EN
                    OP_J:         nextState = JUMP;
`endif
                    default: begin
                        nextState = FAULT;
                        faultNext = FAULT_ILLEGAL;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nextState = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (timeoutHit) begin
                    nextState = FAULT;
                    faultNext = FAULT_TIMEOUT;
                end else if (mem_ready) begin
                    nextState = MEMWB;
                end
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (timeoutHit) begin
                    nextState = FAULT;
                    faultNext = FAULT_TIMEOUT;
                end else if (mem_ready) begin
                    retire = 1'b1;
                end
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                nextState = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_source = 2'b01;
                pc_write  = zero;
                retire    = 1'b1;
            end
`ifdef JUMP_EN
            JUMP: begin
                pc_source = 2'b10;
                pc_write  = 1'b1;
                retire    = 1'b1;
            end
`endif
            FAULT: begin
                nextState = FAULT;
            end
            default: begin
                nextState = IDLE;
            end
        endcase

        // run is only consulted when an instruction completes.
        if (retire) nextState = run ? FETCH : IDLE;
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: an instruction-path model
// predicts state, fault and the control word every cycle, while directed
// stimulus pins key cycles with hand-computed literals.
module tb_multicycle_control;

    localparam int MEM_TIMEOUT = 15;
    localparam int TO_W        = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_read, mem_write, iord, ir_write, pc_write;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       reg_dst, mem_to_reg, reg_write, retire;
    logic [1:0] fault;
    logic [3:0] state;

    int nCompared = 0;
    int nMismatch = 0;

    multicycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
        .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
        .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .retire(retire), .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    logic [15:0] dutVec;
    assign dutVec = {mem_read, mem_write, iord, ir_write, pc_write, pc_source,
                     alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
                     reg_write, retire};

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatch++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // An instruction is a list of steps; the model walks that list, stalling
    // on memory steps and counting stall cycles for the watchdog.
    localparam int M_IDLE = 0, M_RUN = 1, M_FAULT = 2;

    int         mMode  = M_IDLE;
    int         mCls   = 0;     // 0 R-type, 1 lw, 2 sw, 3 beq, 4 jump
    int         mIdx   = 0;     // position in the step list
    int         mWait  = 0;     // stall cycles already spent in this step
    logic [1:0] mFault = 2'b00;

    function automatic int pathLen(input int cls);
        case (cls)
            0: return 4;
            1: return 5;
            2: return 4;
            default: return 3;
        endcase
    endfunction

    function automatic int stepCode(input int cls, input int idx);
        if (idx == 0) return 1;
        if (idx == 1) return 2;
        case (cls)
            0: return (idx == 2) ? 7 : 8;
            1: return (idx == 2) ? 3 : ((idx == 3) ? 4 : 5);
            2: return (idx == 2) ? 3 : 6;
            3: return 9;
            default: return 10;
        endcase
    endfunction

    function automatic int classOf(input logic [5:0] op);
        case (op)
            6'd0:  return 0;
            6'd35: return 1;
            6'd43: return 2;
            6'd4:  return 3;
`ifdef JUMP_EN
            6'd2:  return 4;
`endif
            default: return -1;
        endcase
    endfunction

    function automatic bit isMemStep(input int code);
        return (code == 1) || (code == 4) || (code == 6);
    endfunction

    function automatic int modelCode();
        if (mMode == M_IDLE) return 0;
        if (mMode == M_FAULT) return 15;
        return stepCode(mCls, mIdx);
    endfunction

    function automatic logic modelRetire();
        int code;
        code = modelCode();
        return (mMode == M_RUN) && (mIdx >= 2) && (mIdx == pathLen(mCls) - 1) &&
               (!isMemStep(code) || mem_ready);
    endfunction

    function automatic logic [15:0] expVec(input int code, input logic rdy,
                                           input logic z, input logic ret);
        logic mr, mw, io, irw, pcw, asa, rd, m2r, rw;
        logic [1:0] pcs, asb, aop;
        {mr, mw, io, irw, pcw, asa, rd, m2r, rw} = '0;
        {pcs, asb, aop} = '0;
        case (code)
            1:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            2:  asb = 2'b11;
            3:  begin asa = 1; asb = 2'b10; end
            4:  begin mr = 1; io = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin mw = 1; io = 1; end
            7:  begin asa = 1; aop = 2'b10; end
            8:  begin rw = 1; rd = 1; end
            9:  begin asa = 1; aop = 2'b01; pcs = 2'b01; pcw = z; end
            10: begin pcs = 2'b10; pcw = 1; end
            default: ;
        endcase
        return {mr, mw, io, irw, pcw, pcs, asa, asb, aop, rd, m2r, rw, ret};
    endfunction

    // Model advances on the same edges the DUT samples its inputs.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mMode  <= M_IDLE;
            mCls   <= 0;
            mIdx   <= 0;
            mWait  <= 0;
            mFault <= 2'b00;
        end else if (mMode == M_IDLE) begin
            if (run) begin
                mMode <= M_RUN;
                mIdx  <= 0;
                mWait <= 0;
            end
        end else if (mMode == M_RUN) begin
            if (isMemStep(modelCode()) && !mem_ready) begin
                if (MEM_TIMEOUT != 0 && mWait == MEM_TIMEOUT) begin
                    mMode  <= M_FAULT;
                    mFault <= 2'b10;
                end else begin
                    mWait <= mWait + 1;
                end
            end else begin
                mWait <= 0;
                if (mIdx == 1) begin
                    if (classOf(opcode) < 0) begin
                        mMode  <= M_FAULT;
                        mFault <= 2'b01;
                    end else begin
                        mCls <= classOf(opcode);
                        mIdx <= 2;
                    end
                end else if (mIdx >= 2 && mIdx == pathLen(mCls) - 1) begin
                    mIdx  <= 0;
                    mMode <= run ? M_RUN : M_IDLE;
                end else begin
                    mIdx <= mIdx + 1;
                end
            end
        end
    end

    // Compare DUT against the model mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check("state", {28'd0, state}, modelCode());
            check("fault", {30'd0, fault}, {30'd0, mFault});
            check("controls", {16'd0, dutVec},
                  {16'd0, expVec(modelCode(), mem_ready, zero, modelRetire())});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {28'd0, state}, 32'd0);
        check("reset_fault", {30'd0, fault}, 32'd0);
        check("reset_controls", {16'd0, dutVec}, 32'd0);

        // R-type, zero-wait memory: 0 -> 1 -> 2 -> 7 -> 8 -> 1
        rst = 1'b0; run = 1'b1;
        step(); check("r_fetch", {28'd0, state}, 32'd1);
        step(); check("r_decode", {28'd0, state}, 32'd2);
        step(); check("r_exec", {28'd0, state}, 32'd7);
        step(); check("r_aluwb", {28'd0, state}, 32'd8);
        check("r_regwrite", {31'd0, reg_write}, 32'd1);
        check("r_regdst", {31'd0, reg_dst}, 32'd1);
        check("r_retire", {31'd0, retire}, 32'd1);
        step(); check("r_refetch", {28'd0, state}, 32'd1);
        check("r_retire_drop", {31'd0, retire}, 32'd0);

        // lw with a 3-cycle memory stall
        opcode = 6'd35;
        step(); step(); step();
        check("lw_memrd", {28'd0, state}, 32'd4);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("lw_stall_state", {28'd0, state}, 32'd4);
            check("lw_stall_rd", {30'd0, mem_read, iord}, 32'd3);
        end
        mem_ready = 1'b1;
        step(); check("lw_memwb", {28'd0, state}, 32'd5);
        check("lw_memtoreg", {30'd0, mem_to_reg, reg_dst}, 32'd2);
        step(); check("lw_refetch", {28'd0, state}, 32'd1);

        // beq taken, then not taken
        opcode = 6'd4; zero = 1'b1;
        step(); step(); check("beq_state", {28'd0, state}, 32'd9);
        check("beq_taken", {29'd0, pc_write, pc_source}, 32'd5);
        step(); check("beq_refetch", {28'd0, state}, 32'd1);
        zero = 1'b0;
        step(); step(); check("beq_nt_pcwrite", {31'd0, pc_write}, 32'd0);
        step(); check("beq_nt_refetch", {28'd0, state}, 32'd1);

        // sw with one stall, run dropped at retire
        opcode = 6'd43;
        step(); step(); step(); check("sw_memwr", {28'd0, state}, 32'd6);
        mem_ready = 1'b0;
        step(); check("sw_no_retire", {31'd0, retire}, 32'd0);
        mem_ready = 1'b1; run = 1'b0;
        #1 check("sw_retire", {31'd0, retire}, 32'd1);
        step(); check("sw_idle", {28'd0, state}, 32'd0);
        step(); check("idle_hold", {28'd0, state}, 32'd0);

        // run dropped mid-instruction does not abort
        run = 1'b1; opcode = 6'd0;
        step(); step(); run = 1'b0;
        step(); check("noabort_exec", {28'd0, state}, 32'd7);
        step(); check("noabort_aluwb", {28'd0, state}, 32'd8);
        step(); check("noabort_idle", {28'd0, state}, 32'd0);

        // asynchronous reset in the middle of MEMWR
        run = 1'b1; opcode = 6'd43;
        step(); step(); step(); step();
        check("async_pre_memwr", {28'd0, state}, 32'd6);
        mem_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_state", {28'd0, state}, 32'd0);
        check("async_controls", {16'd0, dutVec}, 32'd0);
        step(); rst = 1'b0; mem_ready = 1'b1;

        // illegal opcode
        opcode = 6'd5;
        step(); step(); step();
        check("illegal_state", {28'd0, state}, 32'd15);
        check("illegal_fault", {30'd0, fault}, 32'd1);
        step(); check("illegal_sticky", {28'd0, state}, 32'd15);
        rst = 1'b1; step(); rst = 1'b0;

        // opcode 2: jump or illegal depending on build
        opcode = 6'd2;
        step(); step(); step();
`ifdef JUMP_EN
        check("jump_state", {28'd0, state}, 32'd10);
        check("jump_pc", {29'd0, pc_write, pc_source}, 32'd6);
        step(); check("jump_refetch", {28'd0, state}, 32'd1);
`else
        check("j_illegal_state", {28'd0, state}, 32'd15);
        check("j_illegal_fault", {30'd0, fault}, 32'd1);
`endif
        rst = 1'b1; step(); rst = 1'b0;

        // watchdog timeout in FETCH
        mem_ready = 1'b0;
        step(); check("to_fetch", {28'd0, state}, 32'd1);
        repeat (15) step();
        check("to_still_fetch", {28'd0, state}, 32'd1);
        step(); check("to_state", {28'd0, state}, 32'd15);
        check("to_fault", {30'd0, fault}, 32'd2);
        check("to_req_drop", {31'd0, mem_read}, 32'd0);
        mem_ready = 1'b1;
        step(); step(); check("to_sticky", {30'd0, fault}, 32'd2);
        rst = 1'b1;
        #1 check("to_rst_state", {28'd0, state}, 32'd0);
        check("to_rst_fault", {30'd0, fault}, 32'd0);
        step(); rst = 1'b0;

        // mem_ready arrives exactly on the timeout cycle: no fault
        opcode = 6'd0; mem_ready = 1'b0;
        step(); repeat (15) step();
        mem_ready = 1'b1;
        #1 check("edge_irwrite", {31'd0, ir_write}, 32'd1);
        step(); check("edge_decode", {28'd0, state}, 32'd2);
        check("edge_nofault", {30'd0, fault}, 32'd0);
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore/Mealy FSM that sequences a shared-memory, single-ALU multicycle MIPS datapath through fetch, decode, execute, memory and writeback steps.
- Supports R-type, lw (35), sw (43) and beq (4).
- Handshakes with a variable-latency memory and reports faults for illegal opcodes and memory timeouts.
- Sits beside the datapath, replacing per-opcode combinational decode with per-cycle control.

Parameters:
- MEM_TIMEOUT, 15: maximum wait cycles in any memory state before a fault. 0 disables the watchdog.
- TO_W, 4: width of the watchdog counter. Must satisfy MEM_TIMEOUT < 2^TO_W.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- run  input  1  enables instruction sequencing
- opcode  input  6  IR[31:26], valid from DECODE onward
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current access this cycle
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- iord  output  1  address mux select: 0=PC, 1=ALUOut
- ir_write  output  1  instruction register load
- pc_write  output  1  PC load
- pc_source  output  2  PC mux select: 00=ALU, 01=ALUOut, 10=jump target
- alu_src_a  output  1  ALU A select: 0=PC, 1=A register
- alu_src_b  output  2  ALU B select: 00=B, 01=4, 10=signext, 11=signext<<2
- alu_op  output  2  00=add, 01=sub, 10=funct
- reg_dst  output  1  destination select: 0=rt, 1=rd
- mem_to_reg  output  1  writeback select: 0=ALUOut, 1=MDR
- reg_write  output  1  register file write
- retire  output  1  one-cycle pulse when an instruction completes
- fault  output  2  00=none, 01=illegal opcode, 10=memory timeout (sticky)
- state  output  4  current state encoding

Behaviour:
- Reset (asynchronous, any time, including mid-instruction):
  - state goes to IDLE; all outputs are 0; watchdog counter and fault are cleared.
- Outputs are decoded combinationally from state. ir_write and pc_write in FETCH are additionally qualified by mem_ready. Any output not listed for a state is 0.
- State encodings and actions:
  - IDLE=0: all outputs 0. Goes to FETCH when run=1.
  - FETCH=1: mem_read=1, alu_src_b=01, ir_write=pc_write=mem_ready. Holds until mem_ready, then goes to DECODE.
  - DECODE=2: alu_src_b=11. Next state by opcode: 0 to EXEC, 35/43 to MEMADR, 4 to BRANCH, anything else to FAULT with fault=01.
  - MEMADR=3: alu_src_a=1, alu_src_b=10. Goes to MEMRD if opcode=35, otherwise MEMWR.
  - MEMRD=4: mem_read=1, iord=1. Holds until mem_ready, then goes to MEMWB.
  - MEMWB=5: reg_write=1, mem_to_reg=1, reg_dst=0. Retires.
  - MEMWR=6: mem_write=1, iord=1. Holds until mem_ready, then retires.
  - EXEC=7: alu_src_a=1, alu_op=10. Goes to ALUWB.
  - ALUWB=8: reg_write=1, reg_dst=1. Retires.
  - BRANCH=9: alu_src_a=1, alu_op=01, pc_source=01, pc_write=zero. Retires.
  - FAULT=15: all datapath controls 0. Held until reset.
- Retire: retire=1 for exactly one cycle in the completing state. Next state is FETCH if run=1, otherwise IDLE.
  - run is sampled only in IDLE and at retire; deasserting run mid-instruction does not abort it.
- Watchdog: the counter increments each cycle spent in FETCH, MEMRD or MEMWR with mem_ready=0, and clears on any state change.
  - If the counter equals MEM_TIMEOUT while mem_ready=0, the next state is FAULT with fault=10. The memory request drops in that next cycle.
  - mem_ready=1 on the same cycle the counter reaches MEM_TIMEOUT: the access completes normally and no fault is raised.
- Latency with zero-wait memory (mem_ready tied 1): R-type 4 cycles, lw 5, sw 4, beq 3.
- mem_ready outside memory states is ignored.

Optional Feature:
- JUMP_EN: when defined, opcode 2 in DECODE goes to JUMP=10, which asserts pc_source=10 and pc_write=1 and retires (3 cycles).
- Without JUMP_EN, opcode 2 is illegal and goes to FAULT with fault=01.

Test Plan:
- Reset, run=1, mem_ready=1, opcode=0: states 0→1→2→7→8→1; reg_write=1 and reg_dst=1 in ALUWB; retire pulses once; 4 cycles per instruction.
- opcode=35, mem_ready low for 3 cycles in MEMRD: state 4 held for exactly 3 extra cycles with mem_read=iord=1; MEMWB shows mem_to_reg=1, reg_dst=0.
- opcode=4: zero=1 gives pc_write=1 and pc_source=01 in BRANCH; zero=0 gives pc_write=0; both return to FETCH after 3 cycles.
- MEM_TIMEOUT=15, mem_ready held 0 in FETCH: after 16 cycles in FETCH, state=15 and fault=10; fault persists until rst, which gives state=0 and all outputs 0.
- opcode=2: with JUMP_EN, state 10 has pc_source=10 and pc_write=1; without JUMP_EN, fault=01 and state=15.
- rst asserted mid-MEMWR: outputs drop to 0 immediately, asynchronously to clk.
